// File: rtl/etc_tile_sched.sv
// Job sequencer for one 4x4 extended-tensor-core tile unit: streams K tile pairs
// into the unit and reduces its results. Optional counters under ETC_SCHED_PERF_EN.
module etc_tile_sched #(
  parameter int W   = 16,
  parameter int KW  = 8,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [KW-1:0]   cmd_ktiles,
  input  logic            tile_valid,
  output logic            tile_ready,
  input  logic [16*W-1:0] tile_a,
  input  logic [16*W-1:0] tile_b,
  output logic [1:0]      etc_op,
  output logic [16*W-1:0] etc_a,
  output logic [16*W-1:0] etc_b,
  input  logic [16*W-1:0] etc_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [16*W-1:0] res_data
`ifdef ETC_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_busy,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LAT-1:0] LAST_STAGE = LAT'(1) << (LAT - 1);

  logic [1:0]      r_state;
  logic [1:0]      r_op;
  logic [KW-1:0]   r_remaining;
  logic [LAT-1:0]  r_pipe;
  logic [16*W-1:0] r_acc;
  logic            r_first;

  logic            w_cmdFire;
  logic            w_tileFire;
  logic            w_absorb;
  logic            w_pipeQuiet;
  logic [16*W-1:0] w_accNext;

  assign w_cmdFire  = cmd_valid && (r_state == S_IDLE);
  assign w_tileFire = tile_valid && (r_state == S_RUN);
  assign w_absorb   = r_pipe[LAT-1];
  // Only the stage being absorbed this cycle may still be occupied.
  assign w_pipeQuiet = ((r_pipe & ~LAST_STAGE) == '0);

  assign cmd_ready  = (r_state == S_IDLE);
  assign tile_ready = (r_state == S_RUN);
  assign res_valid  = (r_state == S_DONE);
  assign res_data   = r_acc;
  assign etc_op     = r_op;
  assign etc_a      = tile_a;
  assign etc_b      = tile_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmdFire) begin
            r_op        <= cmd_op;
            r_remaining <= cmd_ktiles;
            r_state     <= (cmd_ktiles == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_tileFire) begin
            r_remaining <= r_remaining - KW'(1);
            if (r_remaining == KW'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pipeQuiet) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_tileFire;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Element-wise reduce: first result of a job loads, later ones add or take max.
  always_comb begin
    w_accNext = r_acc;
    for (int e = 0; e < 16; e++) begin
      if (r_first) begin
        w_accNext[e*W +: W] = etc_out[e*W +: W];
      end else if (r_op == 2'd0) begin
        w_accNext[e*W +: W] = r_acc[e*W +: W] + etc_out[e*W +: W];
      end else if (etc_out[e*W +: W] > r_acc[e*W +: W]) begin
        w_accNext[e*W +: W] = etc_out[e*W +: W];
      end else begin
        w_accNext[e*W +: W] = r_acc[e*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_first <= 1'b0;
    end else if (w_cmdFire) begin
      r_acc   <= '0;
      r_first <= 1'b1;
    end else if (w_absorb) begin
      r_acc   <= w_accNext;
      r_first <= 1'b0;
    end
  end

`ifdef ETC_SCHED_PERF_EN
  logic w_stallCycle;

  assign w_stallCycle = ((r_state == S_RUN) && !tile_valid) ||
                        ((r_state == S_DONE) && !res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (perf_busy != '1)) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if (w_stallCycle && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_etc_tile_sched.sv
// Self-checking bench for etc_tile_sched: models the 2-cycle tile unit and
// scores each returned result tile against an expected-result queue.
module tb_etc_tile_sched;

  localparam int W   = 16;
  localparam int KW  = 9;
  localparam int LAT = 2;
  localparam int TW  = 16 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [KW-1:0] cmd_ktiles = '0;
  logic          tile_valid = 1'b0;
  logic          tile_ready;
  logic [TW-1:0] tile_a = '0;
  logic [TW-1:0] tile_b = '0;
  logic [1:0]    etc_op;
  logic [TW-1:0] etc_a;
  logic [TW-1:0] etc_b;
  logic [TW-1:0] etc_out = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [TW-1:0] res_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [TW-1:0] expQ[$];
  logic [TW-1:0] jobA[$];
  logic [TW-1:0] jobB[$];

  etc_tile_sched #(.W(W), .KW(KW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ktiles(cmd_ktiles),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_a(tile_a), .tile_b(tile_b),
    .etc_op(etc_op), .etc_a(etc_a), .etc_b(etc_b), .etc_out(etc_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] el(input logic [TW-1:0] t, input int r, input int c);
    return t[(r*4+c)*W +: W];
  endfunction

  // Unit behaviour: matrix multiply mod 2^W for op 0, max over k of min(a,b) otherwise.
  function automatic logic [TW-1:0] unitCalc(input logic [1:0] op, input logic [TW-1:0] a,
                                             input logic [TW-1:0] b);
    logic [TW-1:0] res;
    logic [W-1:0] s;
    logic [W-1:0] mn;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          if (op == 2'd0) begin
            s = s + W'(el(a, r, k) * el(b, k, c));
          end else begin
            mn = (el(a, r, k) < el(b, k, c)) ? el(a, r, k) : el(b, k, c);
            if (mn > s) s = mn;
          end
        end
        res[(r*4+c)*W +: W] = s;
      end
    end
    return res;
  endfunction

  function automatic logic [TW-1:0] fillTile(input logic [W-1:0] v);
    logic [TW-1:0] t;
    for (int e = 0; e < 16; e++) t[e*W +: W] = v;
    return t;
  endfunction

  function automatic logic [TW-1:0] diagTile(input logic [W-1:0] v);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) t[(i*4+i)*W +: W] = v;
    return t;
  endfunction

  // External 4x4 unit: input register then output register sampling op.
  logic [TW-1:0] uA = '0;
  logic [TW-1:0] uB = '0;
  always @(posedge clk) begin
    uA <= etc_a;
    uB <= etc_b;
    etc_out <= unitCalc(etc_op, uA, uB);
  end

  task automatic checkOutput(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one job from jobA/jobB; expected tile is queued up front and scored on handshake.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input int gapPct,
                               input int holdLow);
    int k;
    int n;
    int i;
    int acceptCyc;
    int lastCyc;
    int firstCyc;
    logic leak;
    logic sawTileReady;
    logic stable;
    logic fire;
    logic [TW-1:0] acc;
    logic [TW-1:0] p;
    logic [TW-1:0] held;
    logic [TW-1:0] got;
    logic [TW-1:0] exp;

    k = jobA.size();
    acc = '0;
    for (int t = 0; t < k; t++) begin
      p = unitCalc(op, jobA[t], jobB[t]);
      for (int e = 0; e < 16; e++) begin
        if (t == 0) acc[e*W +: W] = p[e*W +: W];
        else if (op == 2'd0) acc[e*W +: W] = acc[e*W +: W] + p[e*W +: W];
        else if (p[e*W +: W] > acc[e*W +: W]) acc[e*W +: W] = p[e*W +: W];
      end
    end
    expQ.push_back(acc);

    cmd_op = op;
    cmd_ktiles = KW'(k);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    acceptCyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    leak = 1'b0;
    sawTileReady = 1'b0;
    lastCyc = acceptCyc;
    i = 0;
    n = 0;
    while (i < k && n < 5000) begin
      tile_a = jobA[i];
      tile_b = jobB[i];
      tile_valid = ($urandom_range(99) >= gapPct);
      fire = tile_valid && tile_ready;
      if (cmd_ready) leak = 1'b1;
      if (fire) begin
        lastCyc = cyc;
        i++;
      end
      @(posedge clk); #1; n++;
    end
    tile_valid = 1'b0;
    if (n >= 5000) checkOutput({tag, " tile timeout"}, TW'(i), TW'(k));

    n = 0;
    while (!res_valid && n < 100) begin
      if (tile_ready) sawTileReady = 1'b1;
      if (cmd_ready) leak = 1'b1;
      @(posedge clk); #1; n++;
    end
    firstCyc = cyc;
    checkOutput({tag, " res_valid seen"}, TW'(res_valid), TW'(1));
    if (k > 0) begin
      checkOutput({tag, " latency"}, TW'(firstCyc - lastCyc), TW'(LAT + 1));
    end else begin
      checkOutput({tag, " zero-k tile_ready"}, TW'(sawTileReady), TW'(0));
      checkOutput({tag, " zero-k quick result"}, TW'((firstCyc - acceptCyc) <= 2), TW'(1));
    end

    if (holdLow > 0) begin
      held = res_data;
      stable = 1'b1;
      for (int j = 0; j < holdLow; j++) begin
        @(posedge clk); #1;
        if (res_data !== held || res_valid !== 1'b1) stable = 1'b0;
        if (cmd_ready) leak = 1'b1;
      end
      checkOutput({tag, " hold stable"}, TW'(stable), TW'(1));
    end

    res_ready = 1'b1;
    got = res_data;
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput({tag, " result"}, got, exp);
    end else begin
      checkOutput({tag, " scoreboard empty"}, TW'(0), TW'(1));
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput({tag, " cmd_ready low in job"}, TW'(leak), TW'(0));

    jobA.delete();
    jobB.delete();
  endtask

  initial begin
    #1;
    checkOutput("reset cmd_ready", TW'(cmd_ready), TW'(1));
    checkOutput("reset tile_ready", TW'(tile_ready), TW'(0));
    checkOutput("reset res_valid", TW'(res_valid), TW'(0));
    checkOutput("reset res_data", res_data, '0);
    checkOutput("reset etc_op", TW'(etc_op), TW'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    jobA.push_back(diagTile(16'd1)); jobB.push_back(fillTile(16'd2));
    applyStimulus("t1", 2'd0, 0, 0);

    for (int t = 0; t < 2; t++) begin
      jobA.push_back(diagTile(16'd1)); jobB.push_back(diagTile(16'd3));
    end
    applyStimulus("t2a", 2'd0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      jobA.push_back(fillTile(16'd1)); jobB.push_back(fillTile(16'd1));
    end
    applyStimulus("t2b", 2'd0, 0, 0);

    jobA.push_back(fillTile(16'd5)); jobB.push_back(fillTile(16'd5));
    jobA.push_back(fillTile(16'd7)); jobB.push_back(fillTile(16'd7));
    applyStimulus("t3a", 2'd1, 0, 0);

    jobA.push_back(fillTile(16'd7)); jobB.push_back(fillTile(16'd7));
    jobA.push_back(fillTile(16'd5)); jobB.push_back(fillTile(16'd5));
    applyStimulus("t3b", 2'd1, 0, 0);

    for (int t = 0; t < 2; t++) begin
      jobA.push_back(diagTile(16'd1)); jobB.push_back(diagTile(16'd3));
    end
    applyStimulus("t4", 2'd0, 50, 10);

    applyStimulus("t5", 2'd0, 0, 0);

    // Abort a 5-tile job after 3 tiles with an asynchronous reset.
    cmd_op = 2'd0;
    cmd_ktiles = KW'(5);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tile_a = fillTile(16'd9);
    tile_b = fillTile(16'd9);
    tile_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    tile_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 cmd_ready", TW'(cmd_ready), TW'(1));
    checkOutput("t6 res_valid", TW'(res_valid), TW'(0));
    checkOutput("t6 tile_ready", TW'(tile_ready), TW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    jobA.push_back(diagTile(16'd1)); jobB.push_back(fillTile(16'd2));
    applyStimulus("t6 rerun", 2'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
